pixel_filter3x3: RTL
====================

// Module: pixel_filter3x3
// PURPOSE
//  Streaming 3x3 neighbourhood pixel processor; parametrised successor of the single-mode 8-bit stage.
//  Sits between pixel source and sink in the image pipeline; one output pixel per accepted input pixel.
//  Full-throughput valid/ready on both sides, per-frame mode latch, five modes incl. Laplacian and Gaussian.
// PARAMETERS
//  DATA_W      8     pixel width in bits (>=4)
//  IMG_WIDTH   1024  pixels per line (>=3)
//  IMG_HEIGHT  768   lines per frame (>=3)
// PORTS
//  clk        in   1                  single clock, all logic on rising edge
//  rst        in   1                  asynchronous, active-high reset
//  in_data    in   DATA_W             input pixel, raster order
//  in_valid   in   1                  in_data valid
//  in_ready   out  1                  block can accept; transfer when in_valid & in_ready
//  mode       in   3                  000 bypass,001 invert,010 laplacian,011 gauss,100 threshold,others bypass
//  thresh     in   DATA_W             threshold level for mode 100
//  out_data   out  DATA_W             processed pixel
//  out_valid  out  1                  out_data valid; held with data until out_ready
//  out_ready  in   1                  sink accepts; transfer when out_valid & out_ready
//  out_last   out  1                  qualifies final pixel of frame (x=IMG_WIDTH-1,y=IMG_HEIGHT-1)
// BEHAVIOUR
//  Reset: in_ready=1 (combinational), out_valid=0, out_data=0, out_last=0, x=y=0, mode latch=000.
//  Line buffers (2 x IMG_WIDTH x DATA_W) not reset; border rule below makes contents irrelevant.
//  Pipeline: adv = !out_valid | out_ready; in_ready = adv. Stage S1 (window/position) and output reg
//   both move only on adv. Latency: accept at cycle N -> out_valid at N+2 with no backpressure.
//  Back-to-back accepts give one output per cycle; out_ready low freezes S1 and output, no loss/dup.
//  On accept: window shifts left; new column = {lb0[x], lb1[x], in_data}; lb0[x]<=lb1[x]; lb1[x]<=in_data.
//  Counters: x wraps at IMG_WIDTH-1 -> 0, y++; at x=IMG_WIDTH-1,y=IMG_HEIGHT-1 both -> 0 (next frame).
//  Mode latch: mode sampled only when pixel (0,0) accepted; mid-frame changes ignored until next frame.
//  Point modes use the accepted pixel p: bypass p; invert ~p; threshold (p>=thresh)?all-ones:0.
//  Window modes centre on (x-1,y-1) of accepted pixel; output 0 when x<2 or y<2 (no border extension).
//  Laplacian: 4*c-(n+s+e+w) in signed DATA_W+3 bits; clamp to [0, 2^DATA_W-1].
//  Gauss: (corners + 2*edges + 4*c + 8) >> 4 in DATA_W+4 bits; never exceeds max, no clamp.
//  out_last: set with the output of pixel (IMG_WIDTH-1,IMG_HEIGHT-1), else 0.
//  Reset mid-frame: pipeline flushed, in-flight pixels dropped, next accept is pixel (0,0) of a new frame.
// CONFIGURATION
//  FRAME_STATS_EN defined: adds outputs stat_min, stat_max (DATA_W each) and stat_sat_cnt (32b).
//   Tracked over output transfers of a frame; stat_sat_cnt counts Laplacian clamps (either bound).
//   Published registers update on the cycle after the out_last transfer. Reset: min=all-ones, max=0, cnt=0.
//  FRAME_STATS_EN undefined: ports and logic absent; datapath behaviour identical.
// TESTING
//  Reset then mode=000, stream 0..255 with out_ready=1 -> identical sequence, first out_valid 2 cycles after first accept.
//  mode=001, in 8'h3C -> 8'hC3; mode=100 thresh=8'h80, in 8'h7F/8'h80 -> 8'h00/8'hFF.
//  IMG_WIDTH=8,HEIGHT=8, mode=010, flat 8'h40 frame -> 0 everywhere; single 8'hFF centre on 0 -> 8'hFF there, 0 in 4-neighbours (clamped).
//  Same geometry, mode=011, flat 8'h64 -> 0 for x<2|y<2, 8'h64 elsewhere; out_last only on 64th output.
//  Random out_ready (50%) and in_valid gaps over 3 frames -> output matches golden model, no drop/dup, out_data stable while stalled.
//  Change mode at pixel (3,3) -> no effect until next (0,0); assert rst mid-frame -> out_valid=0 same cycle, next frame correct.

Source files
------------

// File: rtl/pixel_filter3x3_if.sv
// Stream bundle for pixel_filter3x3: input pixel stream, mode controls and output pixel stream.
interface pixel_filter3x3_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        mode;
  logic [DATA_W-1:0] thresh;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output in_data, in_valid, mode, thresh, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, mode, thresh, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/pixel_filter3x3.sv
// Streaming 3x3 neighbourhood filter: bypass, invert, Laplacian, Gauss and threshold modes.
// Optional per-frame statistics outputs are added when the macro FRAME_STATS_EN is defined.
module pixel_filter3x3 #(
  parameter int DATA_W     = 8,
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 768
) (
  input  logic              clk,
  input  logic              rst,
  pixel_filter3x3_if.slave  bus
`ifdef FRAME_STATS_EN
  ,
  output logic [DATA_W-1:0] stat_min,
  output logic [DATA_W-1:0] stat_max,
  output logic [31:0]       stat_sat_cnt
`endif
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LW = DATA_W + 3;
  localparam int GW = DATA_W + 4;

  localparam logic [XW-1:0]     X_LAST   = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0]     X_ZERO   = {XW{1'b0}};
  localparam logic [YW-1:0]     Y_ZERO   = {YW{1'b0}};
  localparam logic [XW-1:0]     X_TWO    = XW'(2);
  localparam logic [YW-1:0]     Y_TWO    = YW'(2);
  localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] PIX_ZERO = {DATA_W{1'b0}};
  localparam logic [GW-1:0]     G_ROUND  = {{(GW-4){1'b0}}, 4'd8};

  localparam logic [2:0] MODE_BYPASS = 3'b000;
  localparam logic [2:0] MODE_INVERT = 3'b001;
  localparam logic [2:0] MODE_LAPL   = 3'b010;
  localparam logic [2:0] MODE_GAUSS  = 3'b011;
  localparam logic [2:0] MODE_THRESH = 3'b100;

  logic              adv_s;
  logic              accept_s;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [2:0]        mode_q, mode_d;

  logic              s1_valid_q;
  logic [XW-1:0]     sx_q;
  logic [YW-1:0]     sy_q;
  logic [2:0]        smode_q;
  logic [DATA_W-1:0] sthr_q;
  logic              slast_q;

  logic [DATA_W-1:0] win_q [3][3];
  logic [DATA_W-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_q [IMG_WIDTH];

  logic              out_valid_q;
  logic              out_last_q;
  logic [DATA_W-1:0] out_data_q;

  logic              border_s;
  logic              lap_neg_s;
  logic              lap_ovf_s;
  logic [LW-1:0]     lap_s;
  logic [GW-1:0]     gsum_s;
  logic [DATA_W-1:0] res_s;
  logic [3:0]        gsum_frac_unused;

  // Both S1 and the output register advance together whenever the output slot is free or draining.
  assign adv_s         = ~out_valid_q | bus.out_ready;
  assign accept_s      = adv_s & bus.in_valid;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

  // Raster position advance and per-frame mode latch selection.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    if ((x_q == X_ZERO) && (y_q == Y_ZERO)) begin
      mode_d = bus.mode;
    end else begin
      mode_d = mode_q;
    end
    if (x_q == X_LAST) begin
      x_d = X_ZERO;
      if (y_q == Y_LAST) begin
        y_d = Y_ZERO;
      end else begin
        y_d = y_q + YW'(1);
      end
    end else begin
      x_d = x_q + XW'(1);
      y_d = y_q;
    end
  end

  // Position counters, mode latch and S1 control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= X_ZERO;
      y_q        <= Y_ZERO;
      mode_q     <= MODE_BYPASS;
      s1_valid_q <= 1'b0;
      sx_q       <= X_ZERO;
      sy_q       <= Y_ZERO;
      smode_q    <= MODE_BYPASS;
      sthr_q     <= PIX_ZERO;
      slast_q    <= 1'b0;
    end else begin
      if (adv_s) begin
        s1_valid_q <= bus.in_valid;
      end
      if (accept_s) begin
        x_q     <= x_d;
        y_q     <= y_d;
        mode_q  <= mode_d;
        sx_q    <= x_q;
        sy_q    <= y_q;
        smode_q <= mode_d;
        sthr_q  <= bus.thresh;
        slast_q <= (x_q == X_LAST) && (y_q == Y_LAST);
      end
    end
  end

  // Window and line buffers carry no reset; the border rule masks stale contents.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb0_q[x_q];
      win_q[1][2] <= lb1_q[x_q];
      win_q[2][2] <= bus.in_data;
      lb0_q[x_q]  <= lb1_q[x_q];
      lb1_q[x_q]  <= bus.in_data;
    end
  end

  // Filter arithmetic on the S1 window; the newest pixel sits at win_q[2][2].
  always_comb begin
    border_s = (sx_q < X_TWO) | (sy_q < Y_TWO);
    lap_s    = (LW'(win_q[1][1]) << 2) - LW'(win_q[0][1]) - LW'(win_q[2][1])
             - LW'(win_q[1][0]) - LW'(win_q[1][2]);
    lap_neg_s = lap_s[LW-1];
    lap_ovf_s = ~lap_s[LW-1] & (|lap_s[LW-2:DATA_W]);
    gsum_s   = GW'(win_q[0][0]) + GW'(win_q[0][2]) + GW'(win_q[2][0]) + GW'(win_q[2][2])
             + ((GW'(win_q[0][1]) + GW'(win_q[1][0]) + GW'(win_q[1][2]) + GW'(win_q[2][1])) << 1)
             + (GW'(win_q[1][1]) << 2) + G_ROUND;
    gsum_frac_unused = gsum_s[3:0];
    res_s = win_q[2][2];
    case (smode_q)
      MODE_BYPASS: res_s = win_q[2][2];
      MODE_INVERT: res_s = ~win_q[2][2];
      MODE_LAPL: begin
        if (border_s) begin
          res_s = PIX_ZERO;
        end else if (lap_neg_s) begin
          res_s = PIX_ZERO;
        end else if (lap_ovf_s) begin
          res_s = PIX_MAX;
        end else begin
          res_s = lap_s[DATA_W-1:0];
        end
      end
      MODE_GAUSS: begin
        if (border_s) begin
          res_s = PIX_ZERO;
        end else begin
          res_s = gsum_s[GW-1:4];
        end
      end
      MODE_THRESH: begin
        if (win_q[2][2] >= sthr_q) begin
          res_s = PIX_MAX;
        end else begin
          res_s = PIX_ZERO;
        end
      end
      default: res_s = win_q[2][2];
    endcase
  end

  // Output register holds data and valid until the sink takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= PIX_ZERO;
      out_last_q  <= 1'b0;
    end else if (adv_s) begin
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q & slast_q;
      if (s1_valid_q) begin
        out_data_q <= res_s;
      end
    end
  end

`ifdef FRAME_STATS_EN
  logic              sat_s;
  logic              out_sat_q;
  logic              out_fire_s;
  logic [DATA_W-1:0] run_min_q, run_min_d, run_max_q, run_max_d;
  logic [DATA_W-1:0] pub_min_q, pub_max_q;
  logic [31:0]       run_cnt_q, run_cnt_d, pub_cnt_q;

  assign sat_s        = (smode_q == MODE_LAPL) & ~border_s & (lap_neg_s | lap_ovf_s);
  assign out_fire_s   = out_valid_q & bus.out_ready;
  assign stat_min     = pub_min_q;
  assign stat_max     = pub_max_q;
  assign stat_sat_cnt = pub_cnt_q;

  // Running statistics including the pixel currently being transferred.
  always_comb begin
    if (out_data_q < run_min_q) begin
      run_min_d = out_data_q;
    end else begin
      run_min_d = run_min_q;
    end
    if (out_data_q > run_max_q) begin
      run_max_d = out_data_q;
    end else begin
      run_max_d = run_max_q;
    end
    if (out_sat_q) begin
      run_cnt_d = run_cnt_q + 32'd1;
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  // Saturation flag travels alongside the output pixel; frame totals publish on the last transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sat_q <= 1'b0;
      run_min_q <= PIX_MAX;
      run_max_q <= PIX_ZERO;
      run_cnt_q <= 32'd0;
      pub_min_q <= PIX_MAX;
      pub_max_q <= PIX_ZERO;
      pub_cnt_q <= 32'd0;
    end else begin
      if (adv_s) begin
        out_sat_q <= s1_valid_q & sat_s;
      end
      if (out_fire_s) begin
        if (out_last_q) begin
          pub_min_q <= run_min_d;
          pub_max_q <= run_max_d;
          pub_cnt_q <= run_cnt_d;
          run_min_q <= PIX_MAX;
          run_max_q <= PIX_ZERO;
          run_cnt_q <= 32'd0;
        end else begin
          run_min_q <= run_min_d;
          run_max_q <= run_max_d;
          run_cnt_q <= run_cnt_d;
        end
      end
    end
  end
`endif

endmodule
